// File: rtl/axis_width_conv_wide_narrow.sv
// rtl/axis_width_conv_wide_narrow.sv - wide-to-narrow stream gearbox, MSB-first, tfirst-delimited frames
module axis_width_conv_wide_narrow #(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] s_axis_tdata,
    input  logic         s_axis_tfirst,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tnext,
    output logic [N-1:0] m_axis_tdata,
    output logic         m_axis_tfirst,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tnext,
    output logic [15:0]  bit_count
);

    // Buffer must hold up to N-1 leftover bits plus one full input word.
    localparam int B = M + N - 1;
    localparam logic [15:0] N16 = 16'(N);
    localparam logic [15:0] M16 = 16'(M);

    logic [B-1:0] sreg;
    logic [15:0]  cnt;
    logic         pad;
    logic         first_pend;

    logic         pop;
    logic         accept;
    logic         flush;
    logic [15:0]  cnt_ap;
    logic [B-1:0] sreg_ap;
    logic [B-1:0] ext;

    // Output view, post-pop occupancy, and the accept / pad-flush decisions.
    always_comb begin
        m_axis_tvalid = (cnt >= N16) | pad;
        m_axis_tdata  = sreg[B-1 -: N];
        m_axis_tfirst = first_pend & m_axis_tvalid;
        bit_count     = cnt;

        pop     = m_axis_tvalid & m_axis_tnext;
        cnt_ap  = cnt;
        sreg_ap = sreg;
        if (pop) begin
            if (pad) begin
                // The padded word carries the whole residual; buffer empties.
                cnt_ap  = '0;
                sreg_ap = '0;
            end else begin
                cnt_ap  = cnt - N16;
                sreg_ap = sreg << N;
            end
        end

        // A frame start may only land in an empty buffer so it begins on a word boundary.
        accept = rst & s_axis_tvalid & ~pad & (cnt_ap < N16)
               & (~s_axis_tfirst | (cnt_ap == '0));

        // A pending frame start with a partial residual forces a zero-padded flush word.
        flush = s_axis_tvalid & s_axis_tfirst & ~pad
              & (cnt_ap != '0) & (cnt_ap < N16);

        s_axis_tnext = accept;

        // Left-align the incoming word, then slide it below the bits still held.
        ext           = '0;
        ext[B-1 -: M] = s_axis_tdata;
        ext           = ext >> cnt_ap;
    end

    // Buffer, occupancy, pad mode and frame-start tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg       <= '0;
            cnt        <= '0;
            pad        <= 1'b0;
            first_pend <= 1'b0;
        end else begin
            if (accept) begin
                sreg <= sreg_ap | ext;
                cnt  <= cnt_ap + M16;
            end else begin
                sreg <= sreg_ap;
                cnt  <= cnt_ap;
            end

            if (pop && pad) begin
                pad <= 1'b0;
            end else if (flush) begin
                pad <= 1'b1;
            end

            if (accept && s_axis_tfirst) begin
                first_pend <= 1'b1;
            end else if (pop) begin
                first_pend <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axis_width_conv_wide_narrow.md
Name: axis_width_conv_wide_narrow

Overview:
Gearbox that splits an M-bit stream into N-bit words (M > N). It is the companion stage placed directly downstream of the narrow-to-wide converter, so an N->M->N chain returns the original bit sequence. Packing is MSB-first and frames are delimited by tfirst. The ratio M/N need not be an integer; leftover bits carry into the next input word.

Parameters:
M, 8, input (wide) data width; constraint M > N.
N, 4, output (narrow) data width; constraint N >= 1.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  reset, asynchronous, active-low (rst=0 resets).
s_axis_tdata  in  M  input word.
s_axis_tfirst  in  1  input word is the first of a frame.
s_axis_tvalid  in  1  input word present (FWFT source).
s_axis_tnext  out  1  pop strobe: input word consumed at this edge.
m_axis_tdata  out  N  output word.
m_axis_tfirst  out  1  output word is the first of a frame.
m_axis_tvalid  out  1  output word present.
m_axis_tnext  in  1  downstream consumes the output word at this edge; ignored when m_axis_tvalid=0.
bit_count  out  16  number of bits currently held in the internal buffer.

Behaviour:
- Buffer: left-aligned shift register, B = M+N-1 bits, with occupancy count cnt (0..B). bit_count = cnt, zero-extended.
- Reset (async, rst=0): cnt=0, pad=0, first_pend=0. All outputs are 0. While rst=0, s_axis_tnext=0.
- pop = m_axis_tvalid & m_axis_tnext. cnt_ap = cnt - (pop ? N : 0).
- m_axis_tvalid = (cnt >= N) | pad. This signal is registered-state only and has no combinational path from s_axis_*.
- m_axis_tdata = buf[B-1 -: N]. In pad, the residual bits sit in the MSBs and the LSBs are zero.
- m_axis_tfirst = first_pend & m_axis_tvalid. first_pend clears on pop.
- Accept rule: s_axis_tnext = s_axis_tvalid & ~pad & (cnt_ap < N), with an extra term when s_axis_tfirst=1 that requires cnt_ap == 0.
- Combinational path m_axis_tnext -> s_axis_tnext is allowed. It gives sustained full-rate output, with no bubble at word boundaries.
- On accept: new word is appended directly below the cnt_ap remaining bits, and cnt <= cnt_ap + M. If s_axis_tfirst=1, first_pend <= 1.
- Pad flush: condition is s_axis_tvalid & s_axis_tfirst & 0 < cnt_ap < N and pad=0.
  - Next cycle pad <= 1 and the residual is presented as one zero-padded word with tfirst=first_pend.
  - On its pop: cnt <= 0, pad <= 0.
  - The tfirst word is accepted no earlier than the following edge, which costs exactly one bubble cycle.
- Simultaneous pop and accept in the same edge is legal and must be handled by the cnt_ap arithmetic.
- Latency: word accepted at edge k -> its first N bits are valid on m_axis in cycle k+1.
- Backpressure: while m_axis_tvalid=1 and m_axis_tnext=0, m_axis_tdata and m_axis_tfirst stay stable.
- Stream end without a following tfirst: residual (< N bits) stays buffered indefinitely and is visible in bit_count. It is never emitted or dropped.
- Bit conservation: bits accepted = bits popped (pad zeros excluded) + bit_count.

Test Plan:
1. M=8, N=4, m_axis_tnext tied to m_axis_tvalid; inputs 0xA5(t), 0x3C -> outputs A(t),5,3,C; once warm, one output per cycle with no gaps; bit_count=0 at end.
2. M=12, N=8; inputs 0xABC(t), 0xDEF -> outputs AB(t), CD, EF; bit_count=0.
3. M=12, N=8; inputs 0xABC(t), 0x123(t) -> outputs AB(t), C0 (pad, tfirst=0), one idle cycle, 12(t); bit_count=4 remaining, and a following 0x456 yields 34, 56.
4. M=8, N=4, m_axis_tnext forced 0; feed 1024 random words -> exactly one accepted, m_axis_tdata stable, bit_count=8; release -> remaining data drains in order.
5. Loopback: narrow_wide(N=4, M=8) -> this block (M=8, N=4); 1024 random 4-bit words with random tfirst -> output matches input sequence, tfirst positions and pad nibbles per the upstream padding rule.
6. Assert rst=0 mid-stream with cnt=6 -> same cycle m_axis_tvalid=0, bit_count=0, s_axis_tnext=0; after release, a fresh 0x5A(t) yields 5(t), A.
